// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the countdown timer display path.
//   - timer state codes as driven on stateIn
//   - BCD digit type and the decoder's FSM encoding
//   - fixed display constants (seconds per minute, largest shown minute)
package timer_pkg;

    typedef enum logic [1:0] {
        ST_COUNTING = 2'd0,
        ST_STOPPED  = 2'd1,
        ST_FINISHED = 2'd3
    } timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_BCD,
        S_DONE
    } dec_state_t;

    localparam int unsigned SECS_PER_MIN    = 60;
    localparam int unsigned DISPLAY_MAX_MIN = 99;
    localparam int unsigned DABBLE_STEPS    = 7;

endpackage

// File: rtl/time_digit_decoder_bcd7_dabble.sv
// bcd7_dabble: serial double-dabble converter, 7-bit binary to two BCD digits.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture bin_in and clear the BCD accumulator
//   step       : one conversion step (adjust nibbles >= 5 by +3, then shift)
//   bin_in     : binary value, 0..99
//   tens/units : BCD result, valid after 7 steps following a load
module bcd7_dabble
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  logic [6:0] bin_in,
    output bcd_digit_t tens,
    output bcd_digit_t units
);

    logic [6:0] bin;
    logic [7:0] bcd;
    logic [7:0] adj;
    logic       unused_carry;

    always_comb begin
        adj = bcd;
        if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
    end

    // Inputs never exceed 99, so the tens nibble never carries out.
    assign unused_carry = adj[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            bin <= '0;
            bcd <= '0;
        end else if (load) begin
            bin <= bin_in;
            bcd <= '0;
        end else if (step) begin
            bcd <= {adj[6:0], bin[6]};
            bin <= {bin[5:0], 1'b0};
        end
    end

    assign tens  = bcd[7:4];
    assign units = bcd[3:0];

endmodule

// File: rtl/time_digit_decoder.sv
// time_digit_decoder: converts the timer's remaining seconds into MM:SS BCD
// digits for the VGA character renderer.
//   clk, reset   : clock, synchronous active-high reset
//   tick         : one-cycle sample strobe, accepted only while idle
//   timeIn       : remaining time in seconds (TIME_W bits)
//   stateIn      : timer state code (see timer_pkg)
//   minTens..secUnits : BCD digits, held between updates
//   overflow     : minutes exceeded MIN_MAX, display forced to 99:59
//   blank        : renderer suppresses all digits
//   busy         : conversion in progress
//   digitsValid  : one-cycle pulse when the digits update
// Flow: tick -> TIME_W restoring-divide steps by 60 -> saturation ->
// 7 double-dabble steps -> DONE register; TIME_W+8 cycles tick to output.
// Optional macro TIME_DIGIT_BLINK_EN: blank toggles every BLINK_TICKS
// conversions requested while the timer reports finished.
module time_digit_decoder
    import timer_pkg::*;
#(
    parameter int unsigned TIME_W      = 16,
    parameter int unsigned MIN_MAX     = 99,
    parameter int unsigned BLINK_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [TIME_W-1:0] timeIn,
    input  logic [1:0]        stateIn,
    output bcd_digit_t        minTens,
    output bcd_digit_t        minUnits,
    output bcd_digit_t        secTens,
    output bcd_digit_t        secUnits,
    output logic              overflow,
    output logic              blank,
    output logic              busy,
    output logic              digitsValid
);

    localparam int unsigned CNT_W = $clog2(TIME_W) + 1;

    dec_state_t        state, state_next;
    logic [TIME_W-1:0] quo, quo_next;
    logic [TIME_W-1:0] rem, rem_next;
    logic [TIME_W:0]   rem_shift;
    logic              fits;
    logic [CNT_W-1:0]  step_cnt;
    logic              ovf_pend;
    logic              sat;
    logic [6:0]        min_load, sec_load;
    logic              last_div, last_bcd;
    logic              accept, div_en, bcd_load, bcd_step, done;
    bcd_digit_t        min_t, min_u, sec_t, sec_u;

    assign last_div = (step_cnt == CNT_W'(TIME_W - 1));
    assign last_bcd = (step_cnt == CNT_W'(DABBLE_STEPS - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        div_en     = 1'b0;
        bcd_load   = 1'b0;
        bcd_step   = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: if (tick) begin
                accept     = 1'b1;
                state_next = S_DIV;
            end
            S_DIV: begin
                div_en = 1'b1;
                if (last_div) begin
                    bcd_load   = 1'b1;
                    state_next = S_BCD;
                end
            end
            S_BCD: begin
                bcd_step = 1'b1;
                if (last_bcd) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One restoring-division step: the partial remainder is widened by one
    // bit for the trial subtraction so the compare never wraps.
    always_comb begin
        rem_shift = {rem, quo[TIME_W-1]};
        fits      = (rem_shift >= (TIME_W + 1)'(SECS_PER_MIN));
        rem_next  = fits ? TIME_W'(rem_shift - (TIME_W + 1)'(SECS_PER_MIN))
                         : rem_shift[TIME_W-1:0];
        quo_next  = {quo[TIME_W-2:0], fits};
    end

    // Saturation is folded into the final divide step so the BCD converters
    // load on the same edge the division completes.
    assign sat      = (quo_next > TIME_W'(MIN_MAX));
    assign min_load = sat ? 7'(DISPLAY_MAX_MIN) : quo_next[6:0];
    assign sec_load = sat ? 7'(SECS_PER_MIN - 1) : rem_next[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            quo         <= '0;
            rem         <= '0;
            step_cnt    <= '0;
            ovf_pend    <= 1'b0;
            busy        <= 1'b0;
            digitsValid <= 1'b0;
            overflow    <= 1'b0;
            minTens     <= '0;
            minUnits    <= '0;
            secTens     <= '0;
            secUnits    <= '0;
        end else begin
            digitsValid <= 1'b0;
            if (accept) begin
                quo      <= timeIn;
                rem      <= '0;
                step_cnt <= '0;
                busy     <= 1'b1;
            end
            if (div_en) begin
                quo      <= quo_next;
                rem      <= rem_next;
                step_cnt <= last_div ? '0 : step_cnt + 1'b1;
                if (last_div) ovf_pend <= sat;
            end
            if (bcd_step) step_cnt <= step_cnt + 1'b1;
            if (done) begin
                minTens     <= min_t;
                minUnits    <= min_u;
                secTens     <= sec_t;
                secUnits    <= sec_u;
                overflow    <= ovf_pend;
                digitsValid <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end

`ifdef TIME_DIGIT_BLINK_EN
    logic [$clog2(BLINK_TICKS+1)-1:0] blink_cnt;
    logic                             blink_pend;

    // The toggle decision is made at accept time; it lands on the DONE edge
    // so blank changes together with the digits it applies to.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt  <= '0;
            blink_pend <= 1'b0;
            blank      <= 1'b0;
        end else begin
            if (accept) begin
                if (stateIn == ST_FINISHED) begin
                    if (blink_cnt == $bits(blink_cnt)'(BLINK_TICKS - 1)) begin
                        blink_cnt  <= '0;
                        blink_pend <= 1'b1;
                    end else begin
                        blink_cnt  <= blink_cnt + 1'b1;
                        blink_pend <= 1'b0;
                    end
                end else begin
                    blink_cnt  <= '0;
                    blink_pend <= 1'b0;
                    blank      <= 1'b0;
                end
            end
            if (done && blink_pend) blank <= ~blank;
        end
    end
`else
    logic unused_state;
    assign unused_state = ^stateIn;
    assign blank        = 1'b0;
`endif

    bcd7_dabble u_min (
        .clk    (clk),
        .reset  (reset),
        .load   (bcd_load),
        .step   (bcd_step),
        .bin_in (min_load),
        .tens   (min_t),
        .units  (min_u)
    );

    bcd7_dabble u_sec (
        .clk    (clk),
        .reset  (reset),
        .load   (bcd_load),
        .step   (bcd_step),
        .bin_in (sec_load),
        .tens   (sec_t),
        .units  (sec_u)
    );

endmodule

// File: tb/tb_time_digit_decoder.sv
// Testbench for time_digit_decoder: table-driven conversions checked through a
// scoreboard queue, plus hand-written sequences for dropped ticks, reset
// mid-conversion and (with TIME_DIGIT_BLINK_EN) the blank toggle.
module tb_time_digit_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [15:0] timeIn;
    logic [1:0]  stateIn;
    logic [3:0]  minTens, minUnits, secTens, secUnits;
    logic        overflow, blank, busy, digitsValid;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned valid_count = 0;

    typedef struct {
        logic [15:0] digits;
        logic        ovf;
        logic        blk;
    } exp_t;

    typedef struct {
        logic [15:0] t;
        logic [1:0]  st;
        logic [15:0] digits;
        logic        ovf;
    } vec_t;

    exp_t sb[$];

    int unsigned m_cnt   = 0;
    logic        m_blank = 1'b0;

    time_digit_decoder #(.TIME_W(16), .MIN_MAX(99), .BLINK_TICKS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .timeIn      (timeIn),
        .stateIn     (stateIn),
        .minTens     (minTens),
        .minUnits    (minUnits),
        .secTens     (secTens),
        .secUnits    (secUnits),
        .overflow    (overflow),
        .blank       (blank),
        .busy        (busy),
        .digitsValid (digitsValid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every digitsValid pulse must match the oldest push.
    always @(negedge clk) begin
        if (reset !== 1'b1 && digitsValid === 1'b1) begin
            exp_t e;
            valid_count++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got pulse expected none, digits %h%h%h%h",
                         minTens, minUnits, secTens, secUnits);
            end else begin
                e = sb.pop_front();
                chk("digits",   {16'h0, minTens, minUnits, secTens, secUnits}, {16'h0, e.digits});
                chk("overflow", {31'h0, overflow}, {31'h0, e.ovf});
                chk("blank",    {31'h0, blank},    {31'h0, e.blk});
            end
        end
    end

    task automatic push_exp(input logic [1:0] st, input logic [15:0] digits, input logic ovf);
        exp_t e;
`ifdef TIME_DIGIT_BLINK_EN
        if (st == 2'd3) begin
            m_cnt++;
            if (m_cnt == 4) begin
                m_cnt   = 0;
                m_blank = ~m_blank;
            end
        end else begin
            m_cnt   = 0;
            m_blank = 1'b0;
        end
`endif
        e.digits = digits;
        e.ovf    = ovf;
        e.blk    = m_blank;
        sb.push_back(e);
    endtask

    task automatic send_tick(input logic [15:0] t, input logic [1:0] st);
        @(negedge clk);
        timeIn  = t;
        stateIn = st;
        tick    = 1'b1;
        @(negedge clk);
        tick    = 1'b0;
    endtask

    // Returns edges elapsed from the tick edge until digitsValid is seen.
    task automatic wait_valid(input int unsigned start, output int unsigned n);
        n = start;
        while (digitsValid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_conv(input logic [15:0] t, input logic [1:0] st,
                            input logic [15:0] digits, input logic ovf);
        int unsigned n;
        push_exp(st, digits, ovf);
        send_tick(t, st);
        chk("busy_after_tick", {31'h0, busy}, 32'd1);
        wait_valid(0, n);
        chk("latency", n, 32'd24);
        chk("busy_at_valid", {31'h0, busy}, 32'd0);
        @(negedge clk);
        chk("valid_one_cycle", {31'h0, digitsValid}, 32'd0);
    endtask

    task automatic chk_reset_state(input string name);
        chk(name, {21'h0, minTens, minUnits, secTens, secUnits, overflow, blank, busy, digitsValid},
            32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int unsigned n;
        int unsigned vc;

        vecs[0] = '{16'd754,   2'd0, 16'h1234, 1'b0};
        vecs[1] = '{16'd0,     2'd0, 16'h0000, 1'b0};
        vecs[2] = '{16'd59,    2'd0, 16'h0059, 1'b0};
        vecs[3] = '{16'd60,    2'd1, 16'h0100, 1'b0};
        vecs[4] = '{16'd61,    2'd0, 16'h0101, 1'b0};
        vecs[5] = '{16'd1234,  2'd0, 16'h2034, 1'b0};
        vecs[6] = '{16'd3599,  2'd1, 16'h5959, 1'b0};
        vecs[7] = '{16'd5999,  2'd0, 16'h9959, 1'b0};
        vecs[8] = '{16'd6000,  2'd0, 16'h9959, 1'b1};
        vecs[9] = '{16'd65535, 2'd0, 16'h9959, 1'b1};

        reset   = 1'b1;
        tick    = 1'b0;
        timeIn  = '0;
        stateIn = 2'd0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset_state");
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_conv(vecs[i].t, vecs[i].st, vecs[i].digits, vecs[i].ovf);

        // Second tick 5 cycles into a conversion is dropped.
        vc = valid_count;
        push_exp(2'd0, 16'h1234, 1'b0);
        send_tick(16'd754, 2'd0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        timeIn = 16'd100;
        tick   = 1'b1;
        @(negedge clk);
        n++;
        tick = 1'b0;
        wait_valid(n, n);
        chk("latency_drop", n, 32'd24);
        @(negedge clk);
        chk("busy_after_done", {31'h0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("drop_pulses", valid_count - vc, 32'd1);
        chk("drop_queue_empty", sb.size(), 32'd0);

        // Reset at cycle 10 of a conversion aborts it.
        vc = valid_count;
        send_tick(16'd1234, 2'd0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        m_cnt   = 0;
        m_blank = 1'b0;
        chk_reset_state("abort_reset_state");
        repeat (40) @(negedge clk);
        chk("abort_no_valid", valid_count - vc, 32'd0);
        chk_reset_state("abort_held");
        run_conv(16'd754, 2'd0, 16'h1234, 1'b0);

`ifdef TIME_DIGIT_BLINK_EN
        for (int unsigned k = 0; k < 12; k++)
            run_conv(16'd0, 2'd3, 16'h0000, 1'b0);
        chk("blank_after_12", {31'h0, blank}, 32'd1);
        run_conv(16'd5, 2'd1, 16'h0005, 1'b0);
        chk("blank_cleared", {31'h0, blank}, 32'd0);
`else
        for (int unsigned k = 0; k < 4; k++)
            run_conv(16'd0, 2'd3, 16'h0000, 1'b0);
        chk("blank_never", {31'h0, blank}, 32'd0);
`endif

        chk("queue_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
